// File: rtl/wm_timer_pkg.sv
// Shared types and the per-mode phase duration table for the washing-machine phase timer.
// All durations are counted in prescaled ticks.
package wm_timer_pkg;

    typedef enum logic [1:0] {
        MODE_QUICK,
        MODE_NORMAL,
        MODE_HEAVY,
        MODE_SPIN_ONLY
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_EXPIRED
    } timer_state_t;

    localparam logic [1:0] PH_SOAK  = 2'b00;
    localparam logic [1:0] PH_WASH  = 2'b01;
    localparam logic [1:0] PH_RINSE = 2'b10;
    localparam logic [1:0] PH_SPIN  = 2'b11;

    localparam int DUR_W = 8;

    // Rows by mode, columns by phase code: soak, wash, rinse, spin.
    localparam logic [DUR_W-1:0] DUR [4][4] = '{
        '{8'd2, 8'd4,  8'd3,  8'd2},
        '{8'd4, 8'd8,  8'd6,  8'd4},
        '{8'd8, 8'd16, 8'd12, 8'd6},
        '{8'd0, 8'd0,  8'd0,  8'd5}
    };

    function automatic logic [DUR_W-1:0] dur_lookup(input mode_t mode, input logic [1:0] phase);
        return DUR[mode][phase];
    endfunction

    // Lowest-numbered select wins; no select at all means a normal wash.
    function automatic mode_t decode_mode(input logic m1, input logic m2,
                                          input logic m3, input logic m4);
        mode_t m;
        if (m1)      m = MODE_QUICK;
        else if (m2) m = MODE_NORMAL;
        else if (m3) m = MODE_HEAVY;
        else if (m4) m = MODE_SPIN_ONLY;
        else         m = MODE_NORMAL;
        return m;
    endfunction

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divides clk down to one duration tick every PRESCALE enabled cycles.
// With WM_TIMER_FASTSIM_EN defined every enabled cycle is a tick.
module wm_tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == LAST);

`ifdef WM_TIMER_FASTSIM_EN
    assign tick = en;
`else
    assign tick = en && wrap;
`endif

    // Holding when en is low is what makes a power pause lossless.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase-duration timer for the washing-machine sequencer: loads a duration per phase,
// counts prescaled ticks while powered, and flags timer_done. Option: WM_TIMER_FASTSIM_EN.
module wm_phase_timer
    import wm_timer_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             timer_enable,
    input  logic [1:0]       phase_sel,
    input  logic             mode1,
    input  logic             mode2,
    input  logic             mode3,
    input  logic             mode4,
    input  logic             power_on,
    output logic             timer_done,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    timer_state_t     state;
    mode_t            mode_q;
    logic [1:0]       phase_q;

    mode_t            mode_in;
    mode_t            load_mode;
    logic [CNT_W-1:0] load_dur;
    logic             load_evt;
    logic             counting;
    logic             tick;

    assign mode_in   = decode_mode(mode1, mode2, mode3, mode4);
    assign load_mode = (state == ST_IDLE) ? mode_in : mode_q;
    assign load_dur  = CNT_W'(dur_lookup(load_mode, phase_sel));
    assign load_evt  = timer_enable && ((state == ST_IDLE) || (phase_sel != phase_q));

    // PAUSE with power restored counts in that same cycle, so a pause costs
    // exactly the number of unpowered cycles.
    assign counting = timer_enable && !load_evt && power_on &&
                      ((state == ST_RUN) || (state == ST_PAUSE));

    wm_tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (counting),
        .clr (load_evt),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            phase_q   <= PH_SOAK;
            mode_q    <= MODE_NORMAL;
        end else if (!timer_enable) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else if (load_evt) begin
            phase_q   <= phase_sel;
            remaining <= load_dur;
            if (state == ST_IDLE) begin
                mode_q <= mode_in;
            end
            state <= (load_dur == '0) ? ST_EXPIRED : ST_RUN;
        end else begin
            case (state)
                ST_RUN, ST_PAUSE: begin
                    if (!power_on) begin
                        state <= ST_PAUSE;
                    end else begin
                        state <= ST_RUN;
                        if (tick) begin
                            remaining <= remaining - CNT_W'(1);
                            if (remaining == CNT_W'(1)) begin
                                state <= ST_EXPIRED;
                            end
                        end
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Comparing against the live phase_sel drops done as soon as the controller advances.
    assign timer_done = (state == ST_EXPIRED) && timer_enable && (phase_sel == phase_q);
    assign busy       = (state == ST_RUN) || (state == ST_PAUSE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Bench for wm_phase_timer: directed phase scenarios followed by random stimulus,
// all checked against a cycle-count reference model.
module tb_wm_phase_timer;

    localparam int PRESCALE = 4;
    localparam int CNT_W    = 8;
`ifdef WM_TIMER_FASTSIM_EN
    localparam int P_EFF = 1;
`else
    localparam int P_EFF = PRESCALE;
`endif

    logic             clk;
    logic             rst;
    logic             timer_enable;
    logic [1:0]       phase_sel;
    logic             mode1, mode2, mode3, mode4;
    logic             power_on;
    logic             timer_done;
    logic [CNT_W-1:0] remaining;
    logic             busy;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;

    wm_phase_timer #(
        .PRESCALE(PRESCALE),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .timer_enable(timer_enable),
        .phase_sel   (phase_sel),
        .mode1       (mode1),
        .mode2       (mode2),
        .mode3       (mode3),
        .mode4       (mode4),
        .power_on    (power_on),
        .timer_done  (timer_done),
        .remaining   (remaining),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: tracks powered cycles since load instead of a tick counter
    // m_st: 0 idle, 1 run, 2 paused, 3 expired
    int dur_tab [4][4] = '{'{2, 4, 3, 2}, '{4, 8, 6, 4}, '{8, 16, 12, 6}, '{0, 0, 0, 5}};
    int m_st    = 0;
    int m_phase = 0;
    int m_mode  = 1;
    int m_dur   = 0;
    int m_act   = 0;

    function automatic int pick_mode(input logic a, input logic b, input logic c, input logic d);
        if (a) return 0;
        if (b) return 1;
        if (c) return 2;
        if (d) return 3;
        return 1;
    endfunction

    function automatic void model_step();
        if (rst) begin
            m_st = 0; m_phase = 0; m_mode = 1; m_dur = 0; m_act = 0;
        end else if (!timer_enable) begin
            m_st = 0; m_dur = 0; m_act = 0;
        end else if (m_st == 0 || int'(phase_sel) != m_phase) begin
            if (m_st == 0) m_mode = pick_mode(mode1, mode2, mode3, mode4);
            m_phase = int'(phase_sel);
            m_dur   = dur_tab[m_mode][m_phase];
            m_act   = 0;
            m_st    = (m_dur == 0) ? 3 : 1;
        end else if (m_st == 1 || m_st == 2) begin
            if (power_on) begin
                m_act++;
                m_st = (m_act >= m_dur * P_EFF) ? 3 : 1;
            end else begin
                m_st = 2;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int exp_rem;
        exp_rem = (m_st == 1 || m_st == 2) ? (m_dur - m_act / P_EFF) : 0;
        chk("model_remaining", 32'(remaining), 32'(exp_rem));
        chk("model_busy", 32'(busy), 32'(m_st == 1 || m_st == 2));
        chk("model_done", 32'(timer_done),
            32'(m_st == 3 && timer_enable && int'(phase_sel) == m_phase));
        chk("model_state", 32'(state_dbg), 32'(m_st));
    endtask

    // driver: advance one edge, update model with the inputs seen at that edge, check
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_mode(input logic a, input logic b, input logic c, input logic d);
        mode1 = a; mode2 = b; mode3 = c; mode4 = d;
    endtask

    // counts edges until timer_done, bounded so a stuck DUT still reaches the summary
    task automatic run_until_done(output int n);
        n = 0;
        while (timer_done !== 1'b1 && n < 500) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int pre;
        rst = 1'b1; timer_enable = 1'b0; phase_sel = 2'b00; power_on = 1'b1;
        set_mode(1'b0, 1'b0, 1'b0, 1'b0);

        // reset and normal soak
        step(); step();
        chk("rst_remaining", 32'(remaining), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(timer_done), 32'd0);
        rst = 1'b0;
        set_mode(1'b0, 1'b1, 1'b0, 1'b0);
        timer_enable = 1'b1; phase_sel = 2'b00;
        step();
        chk("soak_load_remaining", 32'(remaining), 32'd4);
        chk("soak_load_busy", 32'(busy), 32'd1);
        run_until_done(n);
        chk("soak_latency", 32'(n), 32'(4 * P_EFF));

        // phase advance: done must drop in the same cycle
        phase_sel = 2'b01;
        #1;
        chk("advance_done_drop", 32'(timer_done), 32'd0);
        check_all();
        step();
        chk("wash_load_remaining", 32'(remaining), 32'd8);
        run_until_done(n);
        chk("wash_latency", 32'(n), 32'(8 * P_EFF));

        // power pause in the middle of spin (normal mode: 4 ticks)
        phase_sel = 2'b11;
        step();
        repeat (5) step();
        pre = 5;
        power_on = 1'b0;
        repeat (10) step();
        pre += 10;
        chk("pause_state", 32'(state_dbg), 32'd2);
        power_on = 1'b1;
        run_until_done(n);
        chk("pause_total_latency", 32'(pre + n), 32'(4 * P_EFF + 10));

        // spin-only: zero-length soak expires at once, spin then takes 5 ticks
        timer_enable = 1'b0;
        step();
        chk("cancel_remaining", 32'(remaining), 32'd0);
        set_mode(1'b0, 1'b0, 1'b0, 1'b1);
        timer_enable = 1'b1; phase_sel = 2'b00;
        step();
        chk("spin_only_soak_expired", 32'(state_dbg), 32'd3);
        chk("spin_only_soak_done", 32'(timer_done), 32'd1);
        // mode inputs must be ignored once a cycle is under way
        set_mode(1'b1, 1'b0, 1'b0, 1'b0);
        phase_sel = 2'b11;
        step();
        chk("spin_only_spin_remaining", 32'(remaining), 32'd5);
        run_until_done(n);
        chk("spin_only_spin_latency", 32'(n), 32'(5 * P_EFF));

        // cancel mid-run
        timer_enable = 1'b0;
        step();
        timer_enable = 1'b1; phase_sel = 2'b01;
        step();
        chk("quick_wash_remaining", 32'(remaining), 32'd4);
        repeat (3) step();
        timer_enable = 1'b0;
        step();
        chk("cancel_mid_remaining", 32'(remaining), 32'd0);
        chk("cancel_mid_busy", 32'(busy), 32'd0);
        chk("cancel_mid_state", 32'(state_dbg), 32'd0);

        // reset while expired
        set_mode(1'b0, 1'b0, 1'b0, 1'b0);
        timer_enable = 1'b1; phase_sel = 2'b10;
        step();
        run_until_done(n);
        chk("none_mode_rinse_latency", 32'(n), 32'(6 * P_EFF));
        rst = 1'b1;
        step();
        chk("rst_expired_done", 32'(timer_done), 32'd0);
        rst = 1'b0;

        // heavy wash: 16 ticks
        timer_enable = 1'b0;
        step();
        set_mode(1'b0, 1'b0, 1'b1, 1'b0);
        timer_enable = 1'b1; phase_sel = 2'b01;
        step();
        run_until_done(n);
        chk("heavy_wash_latency", 32'(n), 32'(16 * P_EFF));

        // random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            else rst = 1'b0;
            timer_enable = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 24) == 0) phase_sel = 2'($urandom_range(0, 3));
            power_on = ($urandom_range(0, 4) != 0);
            set_mode(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            check_all();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
